// File: rtl/nrx_wsg.sv
// Namco 3-voice waveform sound generator: nibble register file, three phase
// accumulators, 256x4 waveform RAM and a six-cycle per-sample sequencer.
module nrx_wsg #(
    parameter int DIV = 250
) (
    input  logic       CLK24M,
    input  logic       RESET_N,
    input  logic       PAUSE,
    input  logic       SND_EN,
    input  logic       WR,
    input  logic [4:0] AD,
    input  logic [3:0] DI,
    input  logic       WV_WE,
    input  logic [7:0] WV_AD,
    input  logic [3:0] WV_DT,
    output logic [7:0] SND
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic [3:0]    regs [32];
    logic [3:0]    wave_ram [256];
    logic [3:0]    rd_q;
    logic [7:0]    p0, p1, p2;
    logic [9:0]    mix;

    logic [19:0] acc0, acc1, acc2;
    logic [19:0] f0, f1, f2;
    logic [2:0]  wave0, wave1, wave2;
    logic [3:0]  vol0, vol1, vol2;

    logic [19:0] acc_cur, f_cur, acc_new;
    logic [2:0]  wave_cur;
    logic [7:0]  rd_addr;

    // Voices 1 and 2 keep only bits [19:4]; their low nibble is hardwired 0.
    assign acc0  = {regs[4], regs[3], regs[2], regs[1], regs[0]};
    assign acc1  = {regs[9], regs[8], regs[7], regs[6], 4'h0};
    assign acc2  = {regs[14], regs[13], regs[12], regs[11], 4'h0};
    assign f0    = {regs[20], regs[19], regs[18], regs[17], regs[16]};
    assign f1    = {regs[25], regs[24], regs[23], regs[22], 4'h0};
    assign f2    = {regs[30], regs[29], regs[28], regs[27], 4'h0};
    assign wave0 = regs[5][2:0];
    assign wave1 = regs[10][2:0];
    assign wave2 = regs[15][2:0];
    assign vol0  = regs[21];
    assign vol1  = regs[26];
    assign vol2  = regs[31];

    always_comb begin
        acc_cur  = acc0;
        f_cur    = f0;
        wave_cur = wave0;
        case (cnt)
            CW'(1): begin
                acc_cur  = acc1;
                f_cur    = f1;
                wave_cur = wave1;
            end
            CW'(2): begin
                acc_cur  = acc2;
                f_cur    = f2;
                wave_cur = wave2;
            end
            default: ;
        endcase
        acc_new = PAUSE ? acc_cur : acc_cur + f_cur;
        rd_addr = {wave_cur, acc_new[19:15]};
    end

    // Sequencer write-back first; a same-cycle CPU write then overrides its nibble.
    always_ff @(posedge CLK24M) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) regs[i] <= 4'h0;
        end else begin
            if (!PAUSE) begin
                case (cnt)
                    CW'(0): begin
                        regs[0] <= acc_new[3:0];
                        regs[1] <= acc_new[7:4];
                        regs[2] <= acc_new[11:8];
                        regs[3] <= acc_new[15:12];
                        regs[4] <= acc_new[19:16];
                    end
                    CW'(1): begin
                        regs[6] <= acc_new[7:4];
                        regs[7] <= acc_new[11:8];
                        regs[8] <= acc_new[15:12];
                        regs[9] <= acc_new[19:16];
                    end
                    CW'(2): begin
                        regs[11] <= acc_new[7:4];
                        regs[12] <= acc_new[11:8];
                        regs[13] <= acc_new[15:12];
                        regs[14] <= acc_new[19:16];
                    end
                    default: ;
                endcase
            end
            if (WR) regs[AD] <= DI;
        end
    end

    // Read-before-write: a load and a read of the same address return old data.
    always_ff @(posedge CLK24M) begin
        if (WV_WE) wave_ram[WV_AD] <= WV_DT;
        rd_q <= wave_ram[rd_addr];
    end

    assign mix = 10'(p0) + 10'(p1) + 10'(p2);

    always_ff @(posedge CLK24M) begin
        if (!RESET_N) begin
            cnt <= '0;
            p0  <= 8'h00;
            p1  <= 8'h00;
            p2  <= 8'h00;
            SND <= 8'h00;
        end else begin
            cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
            case (cnt)
                CW'(1): p0 <= {4'h0, rd_q} * {4'h0, vol0};
                CW'(2): p1 <= {4'h0, rd_q} * {4'h0, vol1};
                CW'(3): p2 <= {4'h0, rd_q} * {4'h0, vol2};
                CW'(5): if (!PAUSE) SND <= SND_EN ? 8'(mix >> 2) : 8'h00;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nrx_wsg.sv
// Directed bench for nrx_wsg: tick-aligned vector tables for the square tone,
// plus hand-written pause, wrap, collision, mix and reset sequences.
module tb_nrx_wsg;

    logic       clk = 1'b0;
    logic       reset_n, pause, snd_en, wr, wv_we;
    logic [4:0] ad;
    logic [3:0] di, wv_dt;
    logic [7:0] wv_ad;
    logic [7:0] snd;

    int errors = 0;
    int checks = 0;
    int tick_no = 0;

    typedef struct {
        int          tick;
        int          cnt;
        logic [7:0]  snd;
        logic [19:0] acc0;
    } vec_t;

    vec_t va [3];
    vec_t vb [8];

    nrx_wsg #(.DIV(250)) dut (
        .CLK24M (clk),
        .RESET_N(reset_n),
        .PAUSE  (pause),
        .SND_EN (snd_en),
        .WR     (wr),
        .AD     (ad),
        .DI     (di),
        .WV_WE  (wv_we),
        .WV_AD  (wv_ad),
        .WV_DT  (wv_dt),
        .SND    (snd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (tick %0d cnt %0d)", name, act, exp, tick_no, dut.cnt);
        end
    endtask

    // One cycle forward; the tick counter steps on entering a cnt==0 cycle.
    task automatic cyc();
        @(negedge clk);
        if (dut.cnt == 0) tick_no++;
    endtask

    task automatic goto(input int t, input int c);
        int guard = 0;
        while (!(tick_no == t && int'(dut.cnt) == c) && guard < 20000) begin
            cyc();
            guard++;
        end
        if (guard >= 20000) begin
            checks++;
            errors++;
            $display("FAIL goto: at tick %0d cnt %0d, required tick %0d cnt %0d", tick_no, dut.cnt, t, c);
        end
    endtask

    task automatic wait_cnt(input int c);
        int guard = 0;
        do begin
            cyc();
            guard++;
        end while (int'(dut.cnt) != c && guard < 1000);
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: cnt %0d required %0d", dut.cnt, c);
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [3:0] d);
        wr = 1'b1;
        ad = a;
        di = d;
        cyc();
        wr = 1'b0;
    endtask

    task automatic wr_wave(input logic [7:0] a, input logic [3:0] d);
        wv_we = 1'b1;
        wv_ad = a;
        wv_dt = d;
        cyc();
        wv_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        goto(v.tick, v.cnt);
        check({tag, "_snd"}, 32'(snd), 32'(v.snd));
        check({tag, "_acc0"}, 32'(dut.acc0), 32'(v.acc0));
    endtask

    task automatic reset_burst(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            ad = 5'($urandom_range(0, 31));
            di = 4'($urandom_range(0, 15));
            cyc();
        end
        wr = 1'b0;
    endtask

    initial begin
        // Square tone before the pause: phase step k equals tick number t.
        va[0] = '{tick: 1,  cnt: 5, snd: 8'h00, acc0: 20'h08000};
        va[1] = '{tick: 1,  cnt: 6, snd: 8'h38, acc0: 20'h08000};
        va[2] = '{tick: 13, cnt: 6, snd: 8'h38, acc0: 20'h68000};
        // After a 5-tick pause the phase lags by 5: k = t - 5.
        vb[0] = '{tick: 19, cnt: 6, snd: 8'h38, acc0: 20'h70000};
        vb[1] = '{tick: 20, cnt: 6, snd: 8'h38, acc0: 20'h78000};
        vb[2] = '{tick: 21, cnt: 5, snd: 8'h38, acc0: 20'h80000};
        vb[3] = '{tick: 21, cnt: 6, snd: 8'h00, acc0: 20'h80000};
        vb[4] = '{tick: 36, cnt: 6, snd: 8'h00, acc0: 20'hF8000};
        vb[5] = '{tick: 37, cnt: 5, snd: 8'h00, acc0: 20'h00000};
        vb[6] = '{tick: 37, cnt: 6, snd: 8'h38, acc0: 20'h00000};
        vb[7] = '{tick: 38, cnt: 6, snd: 8'h38, acc0: 20'h08000};

        pause = 1'b0;
        snd_en = 1'b0;
        wr = 1'b0;
        ad = '0;
        di = '0;
        wv_we = 1'b0;
        wv_ad = '0;
        wv_dt = '0;

        reset_burst(3);
        reset_n = 1'b1;
        check("reset_cnt", 32'(dut.cnt), 32'd0);
        check("reset_snd", 32'(snd), 32'h00);

        // Setup while paused so the accumulators stay at zero.
        pause = 1'b1;
        snd_en = 1'b1;
        for (int s = 0; s < 32; s++) wr_wave(8'(s), (s < 16) ? 4'hF : 4'h0);
        for (int s = 32; s < 64; s++) wr_wave(8'(s), 4'hF);
        wr_reg(5'h15, 4'hF);
        wr_reg(5'h13, 4'h8);
        wr_reg(5'h16, 4'h1);
        wr_reg(5'h1C, 4'h1);
        wait_cnt(10);
        tick_no = 0;
        pause = 1'b0;

        foreach (va[i]) run_vec(va[i], "square_a");

        // Pause for ticks 14..18 with the enable dropped: output must hold.
        goto(13, 10);
        pause = 1'b1;
        snd_en = 1'b0;
        goto(18, 6);
        check("pause_snd", 32'(snd), 32'h38);
        check("pause_acc0", 32'(dut.acc0), 32'h68000);
        check("pause_acc1", 32'(dut.acc1), 32'h000D0);
        check("pause_acc2", 32'(dut.acc2), 32'h00D00);
        goto(18, 10);
        pause = 1'b0;
        snd_en = 1'b1;
        goto(19, 6);
        check("resume_acc1", 32'(dut.acc1), 32'h000E0);

        foreach (vb[i]) run_vec(vb[i], "square_b");

        // Wrap: acc0 = 0xFFFFE, f0 = 1.
        goto(38, 10);
        pause = 1'b1;
        wr_reg(5'h00, 4'hE);
        for (int n = 1; n < 5; n++) wr_reg(5'(n), 4'hF);
        wr_reg(5'h10, 4'h1);
        wr_reg(5'h13, 4'h0);
        pause = 1'b0;
        goto(39, 6);
        check("wrap_pre_acc0", 32'(dut.acc0), 32'hFFFFF);
        check("wrap_pre_snd", 32'(snd), 32'h00);
        goto(40, 6);
        check("wrap_acc0", 32'(dut.acc0), 32'h00000);
        check("wrap_snd", 32'(snd), 32'h38);

        // Collision: f0 = 0x12345, write nibble 0 on the cnt==0 cycle.
        goto(40, 10);
        wr_reg(5'h10, 4'h5);
        wr_reg(5'h11, 4'h4);
        wr_reg(5'h12, 4'h3);
        wr_reg(5'h13, 4'h2);
        wr_reg(5'h14, 4'h1);
        goto(41, 0);
        wr_reg(5'h00, 4'hA);
        check("collide_acc0", 32'(dut.acc0), 32'h1234A);
        goto(42, 1);
        check("collide_next_acc0", 32'(dut.acc0), 32'h2468F);

        // Full mix: every voice on the constant wave at full volume.
        goto(42, 10);
        wr_reg(5'h05, 4'h1);
        wr_reg(5'h0A, 4'h1);
        wr_reg(5'h0F, 4'h1);
        wr_reg(5'h1A, 4'hF);
        wr_reg(5'h1F, 4'hF);
        goto(43, 6);
        check("mix_snd", 32'(snd), 32'hA8);
        goto(44, 6);
        check("mix_steady_snd", 32'(snd), 32'hA8);
        goto(44, 10);
        snd_en = 1'b0;
        goto(45, 5);
        check("mix_off_hold", 32'(snd), 32'hA8);
        goto(45, 6);
        check("mix_off_snd", 32'(snd), 32'h00);

        // Mid-sequence reset: everything clears and restarts at cnt 0.
        goto(45, 10);
        snd_en = 1'b1;
        goto(46, 6);
        check("pre_reset_snd", 32'(snd), 32'hA8);
        goto(46, 8);
        reset_burst(2);
        reset_n = 1'b1;
        check("reset2_cnt", 32'(dut.cnt), 32'd0);
        check("reset2_snd", 32'(snd), 32'h00);
        for (int i = 0; i < 8; i++) cyc();
        check("reset2_cnt_run", 32'(dut.cnt), 32'd8);
        check("reset2_snd_run", 32'(snd), 32'h00);
        check("reset2_acc0", 32'(dut.acc0), 32'h00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrx_wsg.md
# nrx_wsg

Namco 3-voice waveform sound generator (WSG) for the New Rally-X core. It sits between the CPU sound-register writes and the audio output path, and produces the unsigned 8-bit `SND` sample that the top level widens to 16-bit PCM. A free-running divider produces a 96 kHz sample tick from `CLK24M`. On each tick, a sequencer steps three phase accumulators, looks up 4-bit samples in a loadable waveform RAM, scales them by volume, and mixes them.

## Interface
Parameters:
- `DIV` = 250: clock cycles per sample tick (24 MHz / 250 = 96 kHz).

Ports:
- `CLK24M`  in  1  system clock, 24 MHz; all logic on its rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `PAUSE`  in  1  1 = freeze accumulators and hold `SND`.
- `SND_EN`  in  1  sound enable latch; 0 forces the mix to 0.
- `WR`  in  1  CPU sound-register write strobe; one write per asserted cycle.
- `AD`  in  5  register nibble address 0x00–0x1F.
- `DI`  in  4  register write data.
- `WV_WE`  in  1  waveform RAM load strobe.
- `WV_AD`  in  8  waveform RAM address: {wave[2:0], step[4:0]}.
- `WV_DT`  in  4  waveform RAM load data.
- `SND`  out  8  unsigned mixed sample; reset value 0x00.

## Operation
The register file holds 32 nibbles, all 0 after reset. Nibble numbering is LSN first.

| Nibbles | Voice 0 | Voice 1 | Voice 2 |
|---|---|---|---|
| Accumulator | 0x00–0x04 = acc0[19:0] | 0x06–0x09 = acc1[19:4] | 0x0B–0x0E = acc2[19:4] |
| Waveform select | 0x05, bits [2:0] | 0x0A, bits [2:0] | 0x0F, bits [2:0] |
| Frequency | 0x10–0x14 = f0[19:0] | 0x16–0x19 = f1[19:4] | 0x1B–0x1E = f2[19:4] |
| Volume | 0x15 | 0x1A | 0x1F |

- For voices 1 and 2, bits [3:0] of both acc and f are hardwired to 0.
- Waveform RAM: 256×4, written only through `WV_*`. Reads are synchronous with 1-cycle latency. Contents are not cleared by reset.
- Divider `cnt` counts 0..DIV-1 and wraps. The tick is `cnt == 0`.
- Per-voice sequence for voice v:
  - Compute acc_v ← (acc_v + f_v) mod 2^20.
  - Read address = {wave_v, acc_v_new[19:15]}.
  - Product = sample × vol_v, 8 bits, maximum 225.
- Mix: sum = p0 + p1 + p2, 10 bits, maximum 675. On the mix cycle, `SND` ← SND_EN ? sum[9:2] : 0x00. No saturation is needed.
- `PAUSE` = 1:
  - Accumulators do not advance.
  - `SND` holds its last value.
  - The divider keeps running.
  - Register and waveform writes are still accepted.
- Write collision: a CPU write to an accumulator nibble in the same cycle that the sequencer updates that accumulator wins for the written nibble. The other nibbles take the sequencer result.
- A CPU write to f, vol, or wave takes effect at the next sequencer read of that field.

## Timing
- Reset: `RESET_N` = 0 sampled on an edge clears cnt, all registers, all accumulators, the pipeline, and `SND`. Deasserting reset mid-sequence restarts at cnt = 0. No partial sample is emitted.
- Sequencer cycles, counted by cnt value:

| cnt | Action |
|---|---|
| 0 | acc0 update; RAM address for voice 0 issued |
| 1 | acc1 update; address 1 issued; sample 0 returned |
| 2 | acc2 update; address 2 issued; sample 1 returned; p0 registered |
| 3 | sample 2 returned; p1 registered |
| 4 | p2 registered |
| 5 | `SND` updated |

- `SND` changes at most once per DIV cycles. New values are visible from the cycle with cnt == 6.
- A waveform RAM load and a sequencer read to the same address in the same cycle return the old data (read-before-write).
- Register writes are single-cycle; no ready or handshake is used.

## Test plan
- Reset: hold `RESET_N` = 0 for 3 cycles with random `WR` activity, then release. Required: `SND` = 0x00, and cnt = 0 on the first cycle after release.
- Square wave, voice 0:
  - Setup: load wave 0 with steps 0–15 = 0xF and steps 16–31 = 0x0; set vol0 = 0xF and f0 = 0x08000; `SND_EN` = 1.
  - Required: `SND` alternates 0x38 (225>>2) and 0x00 every 16 ticks. Each change appears at cnt == 6.
- Full mix:
  - Setup: all three voices on a constant-0xF wave with vol = 0xF.
  - Required: `SND` = 0xA8 (675>>2) steady.
  - Then set `SND_EN` = 0. Required: `SND` = 0x00 from the next update.
- Accumulator wrap: set acc0 = 0xFFFFF and f0 = 0x00001. Required: acc0 = 0x00000 after one tick, and voice 0 reads step 0.
- Pause: assert `PAUSE` for 5 ticks mid-tone. Required: `SND` and acc0–acc2 are unchanged. After deassertion the sequence resumes from the frozen phase.
- Collision: `WR` to nibble 0x00 with DI = 0xA on the cycle with cnt == 0. Required: acc0[3:0] = 0xA, and acc0[19:4] takes the sum result.
